// File: rtl/rxline_edit_if.sv
// Byte-level link between the line editor and its neighbours: the receive
// strobe coming in, the edited line stream going out.
interface rxline_edit_if #(
    parameter int LGLEN = 7
);
    logic             i_stb;
    logic [7:0]       i_data;
    logic             i_ready;
    logic             o_valid;
    logic [7:0]       o_data;
    logic [LGLEN:0]   o_len;
    logic             o_busy;
    logic             o_drop;

    modport master (
        output i_stb, i_data, i_ready,
        input  o_valid, o_data, o_len, o_busy, o_drop
    );

    modport slave (
        input  i_stb, i_data, i_ready,
        output o_valid, o_data, o_len, o_busy, o_drop
    );
endinterface

// File: rtl/rxline_edit.sv
// Line editor: gathers received bytes into a line with backspace/delete,
// folds CR/LF/CRLF into one LF and streams each finished line downstream.
module rxline_edit #(
    parameter int LGLEN  = 7,
    parameter int MAXLEN = 80
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    rxline_edit_if.slave  bus
);
    localparam int             DEPTH   = 1 << LGLEN;
    localparam logic [LGLEN:0] ONE     = 1;
    localparam logic [LGLEN:0] LEN_MAX = MAXLEN[LGLEN:0];

    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_FLUSH,
        S_TERM
    } state_t;

    state_t         state, state_nx;
    logic [LGLEN:0] len, len_nx;
    logic [LGLEN:0] rdptr, rdptr_nx;
    logic           last_cr, last_cr_nx;
    logic           valid, valid_nx;
    logic [7:0]     odata, odata_nx;
    logic           drop, drop_nx;
    logic           wr_en;

    logic [7:0]     line_mem [0:DEPTH-1];
    logic [LGLEN:0] rdptr_inc;
    logic [7:0]     rd_cur;
    logic [7:0]     rd_next;
    logic           hs;
    logic           is_cr;
    logic           is_lf;
    logic           is_erase;

    assign hs        = valid && bus.i_ready;
    assign rdptr_inc = rdptr + ONE;
    assign rd_cur    = line_mem[rdptr[LGLEN-1:0]];
    assign rd_next   = line_mem[rdptr_inc[LGLEN-1:0]];
    assign is_cr     = (bus.i_data == CH_CR);
    assign is_lf     = (bus.i_data == CH_LF);
    assign is_erase  = (bus.i_data == CH_BS) || (bus.i_data == CH_DEL);

    always_comb begin
        state_nx   = state;
        len_nx     = len;
        rdptr_nx   = rdptr;
        last_cr_nx = last_cr;
        valid_nx   = valid;
        odata_nx   = odata;
        drop_nx    = 1'b0;
        wr_en      = 1'b0;

        unique case (state)
            S_COLLECT: begin
                if (bus.i_stb) begin
                    if (is_cr || (is_lf && !last_cr)) begin
                        last_cr_nx = is_cr;
                        state_nx   = (len != '0) ? S_FLUSH : S_TERM;
                    end else if (is_lf) begin
                        // Second half of a CRLF: the CR already ended the line.
                        last_cr_nx = 1'b0;
                    end else if (is_erase) begin
                        if (len != '0) len_nx = len - ONE;
                        last_cr_nx = 1'b0;
                    end else begin
                        wr_en      = 1'b1;
                        len_nx     = len + ONE;
                        last_cr_nx = 1'b0;
                        if (len + ONE == LEN_MAX) state_nx = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                if (!valid) begin
                    valid_nx = 1'b1;
                    odata_nx = rd_cur;
                end else if (hs) begin
                    rdptr_nx = rdptr_inc;
                    if (rdptr == len - ONE) begin
                        state_nx = S_TERM;
                        odata_nx = CH_LF;
                    end else begin
                        odata_nx = rd_next;
                    end
                end
            end

            S_TERM: begin
                if (!valid) begin
                    valid_nx = 1'b1;
                    odata_nx = CH_LF;
                end else if (hs) begin
                    state_nx = S_COLLECT;
                    len_nx   = '0;
                    rdptr_nx = '0;
                    valid_nx = 1'b0;
                end
            end

            default: begin
                state_nx = S_COLLECT;
            end
        endcase

        // While a line is being emitted nothing is stored; a trailing LF of a
        // CRLF is still absorbed so the pair collapses across the flush.
        if (state != S_COLLECT && bus.i_stb) begin
            if (is_lf && last_cr) last_cr_nx = 1'b0;
            else                  drop_nx    = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= S_COLLECT;
            len     <= '0;
            rdptr   <= '0;
            last_cr <= 1'b0;
            valid   <= 1'b0;
            odata   <= 8'h00;
            drop    <= 1'b0;
        end else begin
            state   <= state_nx;
            len     <= len_nx;
            rdptr   <= rdptr_nx;
            last_cr <= last_cr_nx;
            valid   <= valid_nx;
            odata   <= odata_nx;
            drop    <= drop_nx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en && i_reset_n) line_mem[len[LGLEN-1:0]] <= bus.i_data;
    end

    assign bus.o_valid = valid;
    assign bus.o_data  = odata;
    assign bus.o_len   = len;
    assign bus.o_busy  = (state != S_COLLECT);
    assign bus.o_drop  = drop;
endmodule

// File: tb/tb_rxline_edit.sv
// Bench for rxline_edit: directed scenarios then random traffic, checked each
// cycle against a queue-based model of the line editor.
module tb_rxline_edit;
    localparam int LGLEN  = 7;
    localparam int MAXLEN = 80;

    logic clk = 1'b0;
    logic rst_n;

    rxline_edit_if #(.LGLEN(LGLEN)) bus ();

    rxline_edit #(.LGLEN(LGLEN), .MAXLEN(MAXLEN)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: the line being typed, the bytes still to be emitted, and flags.
    logic [7:0] line_q[$];
    logic [7:0] emit_q[$];
    bit         m_last_cr = 1'b0;
    bit         m_prime   = 1'b0;
    bit         m_drop    = 1'b0;
    bit         known     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit m_valid();
        return (emit_q.size() > 0) && !m_prime;
    endfunction

    task automatic m_terminate(output bit nprime);
        emit_q = line_q;
        emit_q.push_back(8'h0A);
        nprime = 1'b1;
    endtask

    task automatic model_step(input logic stb, input logic [7:0] d, input logic rdy, input logic rstn);
        bit hs, busy, nprime, ndrop;
        if (!rstn) begin
            line_q.delete();
            emit_q.delete();
            m_last_cr = 1'b0;
            m_prime   = 1'b0;
            m_drop    = 1'b0;
            return;
        end
        hs     = m_valid() && rdy;
        busy   = emit_q.size() > 0;
        nprime = 1'b0;
        ndrop  = 1'b0;
        if (busy) begin
            if (stb) begin
                if (d == 8'h0A && m_last_cr) m_last_cr = 1'b0;
                else ndrop = 1'b1;
            end
            if (hs) begin
                void'(emit_q.pop_front());
                if (emit_q.size() == 0) line_q.delete();
            end
        end else if (stb) begin
            if (d == 8'h0D || (d == 8'h0A && !m_last_cr)) begin
                m_last_cr = (d == 8'h0D);
                m_terminate(nprime);
            end else if (d == 8'h0A) begin
                m_last_cr = 1'b0;
            end else if (d == 8'h08 || d == 8'h7F) begin
                if (line_q.size() > 0) void'(line_q.pop_back());
                m_last_cr = 1'b0;
            end else begin
                line_q.push_back(d);
                m_last_cr = 1'b0;
                if (line_q.size() == MAXLEN) m_terminate(nprime);
            end
        end
        m_prime = nprime;
        m_drop  = ndrop;
    endtask

    // One clock: check outputs on the falling edge, then drive and advance the model.
    task automatic cyc(input logic stb, input logic [7:0] d, input logic rdy, input logic rstn);
        @(negedge clk);
        if (known) begin
            chk("o_valid", 32'(bus.o_valid), 32'(m_valid()));
            if (m_valid()) chk("o_data", 32'(bus.o_data), 32'(emit_q[0]));
            chk("o_len", 32'(bus.o_len), 32'(line_q.size()));
            chk("o_busy", 32'(bus.o_busy), 32'(emit_q.size() > 0));
            chk("o_drop", 32'(bus.o_drop), 32'(m_drop));
        end
        bus.i_stb   = stb;
        bus.i_data  = d;
        bus.i_ready = rdy;
        rst_n       = rstn;
        model_step(stb, d, rdy, rstn);
        if (!rstn) known = 1'b1;
    endtask

    task automatic drain();
        int guard = 0;
        while ((emit_q.size() > 0) && guard < 400) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b1);
            guard++;
        end
        if (guard >= 400) chk("drain_timeout", 32'(guard), 32'(0));
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b1, 1'b1);
    endtask

    function automatic logic [7:0] rand_byte(input int term_pct);
        int r;
        r = int'($urandom_range(99));
        if (r < term_pct) return ($urandom_range(1) != 0) ? 8'h0D : 8'h0A;
        if (r < term_pct + 8) return ($urandom_range(1) != 0) ? 8'h08 : 8'h7F;
        return 8'(32'h20 + $urandom_range(94));
    endfunction

    initial begin
        bus.i_stb   = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_ready = 1'b1;
        rst_n       = 1'b0;

        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("rst_valid", 32'(bus.o_valid), 32'(0));
        chk("rst_data",  32'(bus.o_data),  32'(0));
        chk("rst_len",   32'(bus.o_len),   32'(0));
        chk("rst_busy",  32'(bus.o_busy),  32'(0));
        chk("rst_drop",  32'(bus.o_drop),  32'(0));

        // "AB\r\n" back to back
        send(8'h41); send(8'h42); send(8'h0D); send(8'h0A);
        drain();

        // Editing, then an erase on an empty line
        send(8'h41); send(8'h42); send(8'h43); send(8'h08); send(8'h08);
        send(8'h44); send(8'h0D);
        drain();
        send(8'h08);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b1);

        // Forced flush at MAXLEN, then a lone CR
        repeat (MAXLEN) send(8'h30);
        drain();
        send(8'h0D);
        drain();

        // Backpressure while the LF of the CRLF and a stray byte arrive
        send(8'h58); send(8'h0D);
        for (int i = 0; i < 10; i++) begin
            if (i == 2)      cyc(1'b1, 8'h0A, 1'b0, 1'b1);
            else if (i == 5) cyc(1'b1, 8'h59, 1'b0, 1'b1);
            else             cyc(1'b0, 8'h00, 1'b0, 1'b1);
            if (i >= 2) chk("hold_data", 32'(bus.o_data), 32'(8'h58));
        end
        drain();

        // "\r\n\n" -> two empty lines
        send(8'h0D); drain();
        send(8'h0A); drain();
        send(8'h0A); drain();

        // Reset during emission
        send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); send(8'h4F); send(8'h0D);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("post_rst_valid", 32'(bus.o_valid), 32'(0));
        chk("post_rst_len",   32'(bus.o_len),   32'(0));
        send(8'h5A); send(8'h0D);
        drain();

        // Random traffic with frequent line endings and random backpressure
        for (int i = 0; i < 4000; i++) begin
            logic s;
            s = ($urandom_range(99) < 50);
            cyc(s, rand_byte(12), ($urandom_range(99) < 75), 1'b1);
        end
        drain();

        // Dense, rarely terminated traffic to reach forced flushes
        for (int i = 0; i < 4000; i++) begin
            logic s;
            s = ($urandom_range(99) < 80);
            cyc(s, rand_byte(1), ($urandom_range(99) < 85), ($urandom_range(999) != 0));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
